// File: rtl/fb_pkg.sv
// Shared defaults and clear-FSM state type for the framebuffer arbiter.
package fb_pkg;
   localparam int DEF_ADDR_W     = 15;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_FB_DEPTH   = 19200;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } fb_clr_state_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// Small write-request buffer (address + data) used when FB_WRITE_FIFO_EN is defined.
module fb_wr_fifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              empty_o,
   output logic              full_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [ADDR_W+DATA_W-1:0] ent_q [DEPTH];
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            cnt_q, cnt_d;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign {addr_o, data_o} = ent_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push_i) ent_q[wr_ptr_q] <= {addr_i, data_i};
   end
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display read > clear write > application write.
// Optional write buffering is enabled by defining FB_WRITE_FIFO_EN.
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FB_DEPTH   = DEF_FB_DEPTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rvalid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

   fb_clr_state_t     state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] color_q, color_d;
   logic              rvalid_q, rvalid_d, roob_q, roob_d;

   logic              disp_hit, clr_go, wr_go, wq_empty;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;

   assign disp_hit = disp_req && (disp_addr <= LAST_ADDR);
   assign clr_busy = (state_q == CLEAR);
   // A display request owns the slot even when its address is out of range.
   assign clr_go   = clr_busy && !disp_req && wq_empty;

`ifdef FB_WRITE_FIFO_EN
   logic fifo_full;

   fb_wr_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (wr_ack),
      .addr_i  (wr_addr),
      .data_i  (wr_data),
      .pop_i   (wr_go),
      .addr_o  (wa),
      .data_o  (wd),
      .empty_o (wq_empty),
      .full_o  (fifo_full)
   );

   assign wr_ack = reset && wr_req && !fifo_full && !clr_busy;
   // Pending writes drain ahead of the clear so they cannot land on top of it.
   assign wr_go  = !disp_req && !wq_empty;
`else
   logic unused_fifo_cfg;

   assign unused_fifo_cfg = ^FIFO_DEPTH;
   assign wq_empty = 1'b1;
   assign wa       = wr_addr;
   assign wd       = wr_data;
   assign wr_go    = wr_req && !disp_req && !clr_busy;
   assign wr_ack   = reset && wr_go;
`endif

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (reset) begin
         if (disp_req) begin
            mem_en   = disp_hit;
            mem_addr = disp_hit ? disp_addr : '0;
         end else if (clr_go) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = color_q;
         end else if (wr_go && (wa <= LAST_ADDR)) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wa;
            mem_wdata = wd;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      color_d  = color_q;
      rvalid_d = disp_req;
      roob_d   = disp_req && !disp_hit;
      case (state_q)
         IDLE: if (clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
            color_d = clr_color;
         end
         CLEAR: if (clr_go) begin
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         color_q  <= '0;
         rvalid_q <= 1'b0;
         roob_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         color_q  <= color_d;
         rvalid_q <= rvalid_d;
         roob_q   <= roob_d;
      end
   end

   assign disp_rvalid = rvalid_q;
   assign disp_rdata  = (rvalid_q && !roob_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed self-checking bench for fb_arbiter with a behavioural single-port RAM.
module tb_fb_arbiter;
   localparam int AW = 15;
   localparam int DW = 8;
   localparam int DEPTH = 19200;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          disp_req = 1'b0;
   logic [AW-1:0] disp_addr = '0;
   logic [DW-1:0] disp_rdata;
   logic          disp_rvalid;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ack;
   logic          clr_start = 1'b0;
   logic [DW-1:0] clr_color = '0;
   logic          clr_busy;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   logic [DW-1:0] ram [DEPTH];

   int checks = 0;
   int fails  = 0;

   fb_arbiter dut (
      .clk(clk), .reset(reset),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en && int'(mem_addr) < DEPTH) begin
         if (mem_we) ram[int'(mem_addr)] <= mem_wdata;
         else        mem_rdata <= ram[int'(mem_addr)];
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      disp_req = 1'b1; disp_addr = 15'd3; wr_req = 1'b1; wr_addr = 15'd3; wr_data = 8'h11;
      tick(); tick();
      checks++; if (mem_en !== 1'b0)    begin fails++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
      checks++; if (mem_we !== 1'b0)    begin fails++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      checks++; if (wr_ack !== 1'b0)    begin fails++; $display("FAIL rst_wr_ack: got %b want 0", wr_ack); end
      checks++; if (disp_rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %b want 0", disp_rvalid); end
      checks++; if (clr_busy !== 1'b0)  begin fails++; $display("FAIL rst_busy: got %b want 0", clr_busy); end
      checks++; if (mem_addr !== 15'd0 || mem_wdata !== 8'd0 || disp_rdata !== 8'd0)
         begin fails++; $display("FAIL rst_buses: addr %0h wdata %0h rdata %0h want 0", mem_addr, mem_wdata, disp_rdata); end
      disp_req = 1'b0; wr_req = 1'b0;
      reset = 1'b1;
      tick();
   endtask

   // Loads RAM[i]=i through the direct write path, then streams 10 reads.
   task automatic test_disp_read();
      for (int i = 0; i < 10; i++) begin
         wr_req = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
         #1;
         checks++;
         if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(i))
            begin fails++; $display("FAIL preload_wr[%0d]: ack %b we %b addr %0d want 1 1 %0d", i, wr_ack, mem_we, mem_addr, i); end
         tick();
      end
      wr_req = 1'b0;
      for (int c = 0; c <= 10; c++) begin
         checks++;
         if (disp_rvalid !== (c >= 1)) begin fails++; $display("FAIL rd_rvalid[%0d]: got %b want %b", c, disp_rvalid, c >= 1); end
         if (c >= 1) begin
            checks++;
            if (disp_rdata !== DW'(c - 1)) begin fails++; $display("FAIL rd_data[%0d]: got %0h want %0h", c, disp_rdata, c - 1); end
         end
         disp_req = (c < 10); disp_addr = AW'(c);
         #1;
         checks++;
         if (mem_en !== (c < 10) || mem_we !== 1'b0)
            begin fails++; $display("FAIL rd_mem_en[%0d]: en %b we %b want %b 0", c, mem_en, mem_we, c < 10); end
         tick();
      end
      checks++; if (disp_rvalid !== 1'b0) begin fails++; $display("FAIL rd_rvalid_end: got %b want 0", disp_rvalid); end
   endtask

   task automatic test_write_vs_disp();
      wr_req = 1'b1; wr_addr = 15'd5; wr_data = 8'hA3;
      disp_req = 1'b1; disp_addr = 15'd0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL wvd_blocked[%0d]: ack %b we %b want 0 0", k, wr_ack, mem_we); end
         tick();
      end
      disp_req = 1'b0;
      #1;
      checks++;
      if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd5 || mem_wdata !== 8'hA3)
         begin fails++; $display("FAIL wvd_issue: ack %b we %b addr %0d data %0h want 1 1 5 a3", wr_ack, mem_we, mem_addr, mem_wdata); end
      tick();
      wr_req = 1'b0;
      checks++; if (ram[5] !== 8'hA3) begin fails++; $display("FAIL wvd_ram5: got %0h want a3", ram[5]); end
   endtask

   task automatic test_oob();
      disp_req = 1'b1; disp_addr = 15'd5;
      tick();
      disp_addr = 15'd19200;
      #1;
      checks++; if (mem_en !== 1'b0) begin fails++; $display("FAIL oob_rd_en: got %b want 0", mem_en); end
      checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 8'hA3)
         begin fails++; $display("FAIL oob_prev_rd: rvalid %b data %0h want 1 a3", disp_rvalid, disp_rdata); end
      tick();
      disp_req = 1'b0;
      checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 8'h00)
         begin fails++; $display("FAIL oob_rd_data: rvalid %b data %0h want 1 0", disp_rvalid, disp_rdata); end
      wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 8'h77;
      #1;
      checks++; if (wr_ack !== 1'b1 || mem_en !== 1'b0)
         begin fails++; $display("FAIL oob_wr: ack %b en %b want 1 0", wr_ack, mem_en); end
      tick();
      wr_req = 1'b0;
   endtask

   task automatic test_clear();
      int n = 0;
      int ack_err = 0;
      int bad = 0;
      clr_start = 1'b1; clr_color = 8'h1C;
      tick();
      clr_start = 1'b0;
      wr_req = 1'b1; wr_addr = 15'd7; wr_data = 8'h42;
      while (clr_busy === 1'b1 && n < 20000) begin
         if (wr_ack !== 1'b0) ack_err++;
         clr_start = (n == 50); clr_color = (n == 50) ? 8'hFF : 8'h1C;
         tick();
         n++;
      end
      clr_start = 1'b0;
      checks++; if (n != DEPTH) begin fails++; $display("FAIL clr_busy_len: got %0d want %0d", n, DEPTH); end
      checks++; if (ack_err != 0) begin fails++; $display("FAIL clr_wr_acked_busy: got %0d want 0", ack_err); end
      checks++; if (wr_ack !== 1'b1 || mem_addr !== 15'd7)
         begin fails++; $display("FAIL clr_wr_after: ack %b addr %0d want 1 7", wr_ack, mem_addr); end
      tick();
      wr_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) if (i != 7 && ram[i] !== 8'h1C) bad++;
      checks++; if (bad != 0) begin fails++; $display("FAIL clr_ram_fill: %0d entries not 1c, want 0", bad); end
      checks++; if (ram[7] !== 8'h42) begin fails++; $display("FAIL clr_ram7: got %0h want 42", ram[7]); end
   endtask

   task automatic test_reset_during_clear();
      int n = 0;
      clr_start = 1'b1; clr_color = 8'h55;
      tick();
      clr_start = 1'b0;
      disp_req = 1'b1; disp_addr = 15'd3;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (mem_we !== 1'b0 || mem_addr !== 15'd3) begin fails++; $display("FAIL stall_disp[%0d]: we %b addr %0d want 0 3", k, mem_we, mem_addr); end
         tick();
      end
      disp_req = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 15'd0 || mem_wdata !== 8'h55)
         begin fails++; $display("FAIL stall_resume: we %b addr %0d data %0h want 1 0 55", mem_we, mem_addr, mem_wdata); end
      while (!(mem_we === 1'b1 && mem_addr === 15'd100) && n < 200) begin
         tick();
         n++;
      end
      checks++; if (n >= 200) begin fails++; $display("FAIL rdc_reach100: got %0d cycles want <200", n); end
      reset = 1'b0; disp_req = 1'b1; disp_addr = 15'd3;
      #1;
      checks++; if (mem_en !== 1'b0 || clr_busy !== 1'b0 || mem_addr !== 15'd0 || mem_wdata !== 8'd0 || disp_rvalid !== 1'b0)
         begin fails++; $display("FAIL rdc_outputs: en %b busy %b addr %0d wdata %0h rvalid %b want all 0", mem_en, clr_busy, mem_addr, mem_wdata, disp_rvalid); end
      tick(); tick();
      disp_req = 1'b0;
      reset = 1'b1;
      tick();
      checks++; if (clr_busy !== 1'b0 || disp_rvalid !== 1'b0 || mem_en !== 1'b0)
         begin fails++; $display("FAIL rdc_after: busy %b rvalid %b en %b want 0 0 0", clr_busy, disp_rvalid, mem_en); end
      checks++; if (ram[99] !== 8'h55 || ram[100] !== 8'h1C || ram[101] !== 8'h1C)
         begin fails++; $display("FAIL rdc_ram: r99 %0h r100 %0h r101 %0h want 55 1c 1c", ram[99], ram[100], ram[101]); end
   endtask

`ifdef FB_WRITE_FIFO_EN
   task automatic test_fifo();
      int idx = 0;
      disp_req = 1'b1; disp_addr = 15'd0;
      for (int i = 0; i < 4; i++) begin
         wr_req = 1'b1; wr_addr = AW'(20 + i); wr_data = DW'(8'h60 + i);
         #1;
         checks++; if (wr_ack !== 1'b1) begin fails++; $display("FAIL fifo_push[%0d]: got %b want 1", i, wr_ack); end
         tick();
      end
      idx = 4;
      wr_addr = 15'd24; wr_data = 8'h64;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (wr_ack !== 1'b0) begin fails++; $display("FAIL fifo_full[%0d]: got %b want 0", k, wr_ack); end
         tick();
      end
      disp_req = 1'b0;
      for (int j = 0; j < 6; j++) begin
         #1;
         checks++;
         if (mem_we !== 1'b1 || mem_addr !== AW'(20 + j) || mem_wdata !== DW'(8'h60 + j))
            begin fails++; $display("FAIL fifo_drain[%0d]: we %b addr %0d data %0h want 1 %0d %0h", j, mem_we, mem_addr, mem_wdata, 20 + j, 8'h60 + j); end
         if (wr_ack === 1'b1 && idx < 6) idx++;
         tick();
         wr_req = (idx < 6); wr_addr = AW'(20 + idx); wr_data = DW'(8'h60 + idx);
      end
      wr_req = 1'b0;
      checks++; if (idx != 6) begin fails++; $display("FAIL fifo_acks: got %0d want 6", idx); end
   endtask
`endif

   initial begin
      test_reset();
      test_disp_read();
      test_write_vs_disp();
      test_oob();
      test_clear();
      test_reset_during_clear();
`ifdef FB_WRITE_FIFO_EN
      test_fifo();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter: ADDR_W, 15, framebuffer address width.
REQ-002 Parameter: DATA_W, 8, pixel width (RGB332).
REQ-003 Parameter: FB_DEPTH, 19200, valid pixel count (160x120); addresses 0..FB_DEPTH-1.
REQ-004 Parameter: FIFO_DEPTH, 4, write-buffer entries (used only with FB_WRITE_FIFO_EN).
REQ-005 Port: clk  in  1  single clock for all logic.
REQ-006 Port: reset  in  1  asynchronous, active-low reset.
REQ-007 Port: disp_req  in  1  display read request, one pixel per cycle.
REQ-008 Port: disp_addr  in  ADDR_W  display read address.
REQ-009 Port: disp_rdata  out  DATA_W  read pixel, valid with disp_rvalid.
REQ-010 Port: disp_rvalid  out  1  read-data strobe.
REQ-011 Port: wr_req / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  application write request.
REQ-012 Port: wr_ack  out  1  write-accepted pulse.
REQ-013 Port: clr_start  in  1  start full-screen clear.
REQ-014 Port: clr_color  in  DATA_W  clear colour, sampled at start.
REQ-015 Port: clr_busy  out  1  clear in progress.
REQ-016 Port: mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_W / DATA_W  single-port RAM control.
REQ-017 Port: mem_rdata  in  DATA_W  RAM read data, one-cycle synchronous latency.

Function
REQ-018 SHALL grant exactly one memory access per cycle, priority: display read > clear write > application write.
REQ-019 mem_* SHALL be combinational from the current-cycle grant; mem_en low when nothing is granted.
REQ-020 disp_rvalid SHALL assert exactly one cycle after each cycle with disp_req high; disp_rdata = mem_rdata in that cycle.
REQ-021 disp_addr >= FB_DEPTH: no RAM access, disp_rvalid still asserts one cycle later, disp_rdata = 0.
REQ-022 Clear FSM states IDLE, CLEAR: IDLE->CLEAR on clr_start (colour latched, counter=0); CLEAR->IDLE after writing address FB_DEPTH-1.
REQ-023 clr_busy SHALL be high from the cycle after clr_start through the cycle of the last clear write; clr_start while busy ignored.
REQ-024 In CLEAR, each cycle without disp_req SHALL write latched colour to the counter address and increment the counter; display cycles stall the counter.
REQ-025 Direct mode: wr_ack SHALL pulse in the cycle the write is issued to RAM; writer holds wr_req/addr/data stable until wr_ack.
REQ-026 Application writes SHALL NOT be acked while clr_busy is high.
REQ-027 wr_addr >= FB_DEPTH: acked per REQ-025 timing, mem_en low (write dropped).

Reset
REQ-028 On reset low: disp_rvalid, wr_ack, clr_busy, mem_en, mem_we = 0; mem_addr, mem_wdata, disp_rdata = 0; FSM IDLE; counter 0; FIFO empty.
REQ-029 Reset during CLEAR SHALL abort the clear; after release FSM is IDLE and no pending read strobe survives.

Configuration
REQ-030 Macro FB_WRITE_FIFO_EN defined: writes enter a FIFO_DEPTH FIFO; wr_ack = wr_req && !full in the same cycle; FIFO drains in cycles not taken by display/clear.
REQ-031 With FB_WRITE_FIFO_EN: push and pop in the same cycle keep occupancy; clr_start asserts clr_busy at once but clear writes begin only once the FIFO is empty.
REQ-032 Without FB_WRITE_FIFO_EN: no FIFO logic; direct handshake per REQ-025.

Structure
REQ-033 Package fb_pkg SHALL hold ADDR_W/DATA_W/FB_DEPTH defaults and typedef fb_clr_state_t {IDLE, CLEAR}.
REQ-034 FIFO SHALL be sub-module fb_wr_fifo, instantiated only under FB_WRITE_FIFO_EN.

Verification
REQ-035 disp_req high 10 cycles, addrs 0..9, RAM preloaded addr=data -> disp_rvalid 10 cycles starting +1, data 0..9.
REQ-036 wr_req addr 5 data 0xA3 while disp_req high 3 cycles -> wr_ack on 4th cycle, RAM[5]=0xA3.
REQ-037 clr_start colour 0x1C, no display traffic -> clr_busy high FB_DEPTH cycles, all RAM = 0x1C, wr_req held meanwhile acked only after busy drops.
REQ-038 reset low at clear counter 100 -> outputs 0 immediately, RAM[100..] unchanged, clr_busy 0 after release.
REQ-039 FB_WRITE_FIFO_EN, disp_req held high, 6 back-to-back writes -> 4 acked, wr_ack low 5th; release disp_req -> 4 RAM writes in order, then remaining 2 acked.
REQ-040 disp_addr 19200 -> no mem_en, disp_rvalid +1 with disp_rdata 0.
